// File: rtl/deserializer.sv
// Narrow-to-wide channel deserializer.
// Collects D chunks of Nin bits, LSB chunk first, into one Nout-bit word.
// One word waits in the output register while the next word is collected,
// so collection of word k+1 overlaps the wait for out_a on word k.
module deserializer #(
    parameter int Nin  = 16,
    parameter int Nout = 36
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_v,
    input  logic [Nin-1:0]  in_d,
    output logic            in_a,
    output logic            out_v,
    output logic [Nout-1:0] out_d,
    input  logic            out_a
);

    // Chunks per word, width of the last chunk's useful slice, counter width.
    localparam int D      = (Nout % Nin == 0) ? Nout / Nin : Nout / Nin + 1;
    localparam int LAST_W = Nout - Nin * (D - 1);
    localparam int CW     = (D > 1) ? $clog2(D) : 1;

    logic            is_final;
    logic [Nout-1:0] word_in;
    logic            stall;
    logic            in_fire;
    logic            out_fire;
    logic            ofull_q, ofull_d;
    logic [Nout-1:0] obuf_q, obuf_d;

    // Bits of in_d above the word width are deliberately dropped.
    logic unused_in;
    assign unused_in = ^in_d;

    // Handshake: only the final chunk can be held back by a full output word.
    always_comb begin
        stall    = is_final & ofull_q & ~out_a;
        in_a     = in_v & ~stall & ~reset;
        in_fire  = in_a;
        out_fire = ofull_q & out_a;
    end

    generate
        if (D > 1) begin : g_multi
            logic [CW-1:0]          cnt_q, cnt_d;
            logic [Nin*(D-1)-1:0]   acc_flat;

            assign is_final = (cnt_q == CW'(D - 1));
            assign word_in  = {in_d[LAST_W-1:0], acc_flat};

            // Chunk index: advances on every accepted chunk, wraps only on the final one.
            always_comb begin
                cnt_d = cnt_q;
                if (in_fire) begin
                    cnt_d = is_final ? '0 : cnt_q + CW'(1);
                end
            end

            // Chunk index register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            for (genvar gi = 0; gi < D - 1; gi++) begin : g_slot
                logic [Nin-1:0] slot_q, slot_d;

                // Capture the chunk whose index matches this slot.
                always_comb begin
                    slot_d = slot_q;
                    if (in_fire && cnt_q == CW'(gi)) begin
                        slot_d = in_d;
                    end
                end

                // Partial-word slot register.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        slot_q <= '0;
                    end else begin
                        slot_q <= slot_d;
                    end
                end

                assign acc_flat[gi*Nin +: Nin] = slot_q;
            end
        end else begin : g_single
            // Every chunk is a whole word.
            assign is_final = 1'b1;
            assign word_in  = in_d[Nout-1:0];
        end
    endgenerate

    // Output word: a final chunk loads a new word (even as the old one leaves),
    // otherwise an output transfer empties the register.
    always_comb begin
        ofull_d = ofull_q;
        obuf_d  = obuf_q;
        if (in_fire && is_final) begin
            ofull_d = 1'b1;
            obuf_d  = word_in;
        end else if (out_fire) begin
            ofull_d = 1'b0;
        end
    end

    // Output word register and its valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ofull_q <= 1'b0;
            obuf_q  <= '0;
        end else begin
            ofull_q <= ofull_d;
            obuf_q  <= obuf_d;
        end
    end

    assign out_v = ofull_q;
    assign out_d = obuf_q;

endmodule
